accel_sequencer: RTL
====================

ACCEL_SEQUENCER -- requirements
Module: accel_sequencer

Interface
REQ-001 Parameter ARRAY_W, default `ARRAYWIDTH (8), array rows/columns and weight-load beats.
REQ-002 Parameter ROWS_W, default 8, width of cfg_rows.
REQ-003 Parameter PIPE_LAT, default 2*ARRAY_W, cycles from first streamed activation to first valid out_sum row.
REQ-004 Ports: clk  in  1  single clock; rst  in  1  reset, asynchronous, active-high.
REQ-005 start  in  1  tile start request, sampled only in IDLE.
REQ-006 abort  in  1  cancel current tile.
REQ-007 cfg_rows  in  ROWS_W  activation rows in tile; cfg_relu  in  1  ReLU on drain; cfg_acc  in  1  accumulate into output buffer; cfg_first  in  1  clear accumulators at tile start.
REQ-008 busy  out  1  state != IDLE; done  out  1  one-cycle tile-complete pulse.
REQ-009 Outputs, 1 bit each: weight_buffer_load_en, weight_buffer_out_en, write_weight_en, input_buffer_load_en, input_buffer_delay_clear, input_buffer_out_en, output_buffer_load_clear, output_buffer_acc_clear, output_buffer_load_en, output_buffer_acc_enable, output_buffer_out_en, relu_en.

Function
REQ-010 FSM states: IDLE, WLOAD, WWRITE, ALOAD, STREAM, DRAIN, DONE; all outputs registered.
REQ-011 IDLE: all enables 0; start=1 with cfg_rows!=0 latches cfg_* and moves to WLOAD next cycle.
REQ-012 IDLE, start=1 with cfg_rows==0: done=1 next cycle, stays IDLE, no enables.
REQ-013 start during busy is ignored; latched config unchanged until next IDLE.
REQ-014 WLOAD: weight_buffer_load_en=1 for exactly ARRAY_W cycles, then WWRITE.
REQ-015 WWRITE: weight_buffer_out_en=1 and write_weight_en=1 for exactly ARRAY_W cycles, then ALOAD.
REQ-016 ALOAD: input_buffer_load_en=1 for cfg_rows cycles; input_buffer_delay_clear=1 and output_buffer_load_clear=1 on first ALOAD cycle only; output_buffer_acc_clear=1 on first ALOAD cycle only if cfg_first.
REQ-017 STREAM: input_buffer_out_en=1 for cfg_rows+PIPE_LAT cycles; with STREAM cycle index i from 0, output_buffer_load_en=1 for PIPE_LAT <= i < PIPE_LAT+cfg_rows.
REQ-018 output_buffer_acc_enable = cfg_acc AND output_buffer_load_en, same cycles.
REQ-019 DRAIN: output_buffer_out_en=1 for cfg_rows cycles; relu_en=cfg_relu during DRAIN, 0 elsewhere.
REQ-020 DONE: done=1 for one cycle, all enables 0, then IDLE.
REQ-021 Busy cycles per tile = 2*ARRAY_W + 3*cfg_rows + PIPE_LAT + 1; start sampled at edge T gives done high in cycle T+that count.
REQ-022 Phase counter sized to hold cfg_rows+PIPE_LAT at cfg_rows = 2^ROWS_W-1 without wrap.
REQ-023 abort=1 in any non-IDLE state: next edge to IDLE, all enables 0, done not asserted; abort in IDLE has no effect.
REQ-024 abort and start same cycle in IDLE: start wins (abort ignored in IDLE).
REQ-025 Exactly one phase enable group active per cycle; weight and activation enables never overlap.

Reset
REQ-026 rst=1 forces IDLE, counter 0, latched config 0, every output 0 immediately, independent of clk.
REQ-027 Reset mid-tile discards tile; no done pulse on deassertion.
REQ-028 First start accepted on first rising clk edge after rst deasserts.

Structure
REQ-029 State encodings and PIPE_LAT default live in shared config include beside ARRAYWIDTH/DATASIZE.
REQ-030 One sub-module: accel_phase_counter (load value, decrement, zero flag), instantiated once.
REQ-031 No datapath; block drives only enables of existing buffer, array and ReLU blocks.

Verification (ARRAY_W=4, PIPE_LAT=8)
REQ-032 cfg_rows=3, start at edge T -> weight_buffer_load_en T+1..T+4, write_weight_en T+5..T+8, input_buffer_load_en T+9..T+11, input_buffer_out_en T+12..T+22, output_buffer_load_en T+20..T+22, output_buffer_out_en T+23..T+25, done T+26.
REQ-033 cfg_rows=3, cfg_relu=1, cfg_acc=1, cfg_first=1 -> acc_clear only at T+9, acc_enable T+20..T+22, relu_en T+23..T+25.
REQ-034 cfg_rows=0 start -> done one cycle later, busy never 1, no enables.
REQ-035 abort at T+15 -> all outputs 0 from T+16, busy 0, no done; new start accepted at T+16.
REQ-036 rst pulse at T+10 between edges -> outputs 0 asynchronously; start during busy (T+5) ignored, timing identical to REQ-032.
REQ-037 cfg_rows=255 -> STREAM lasts 263 cycles, load_en exactly 255 cycles, done at T+2*4+765+8+1.

Source files
------------

// File: rtl/accel_sequencer_pkg.sv
// Shared configuration for the accelerator sequencer: array geometry,
// default pipeline latency, FSM state encoding and latched tile flags.
package accel_sequencer_pkg;

  localparam int unsigned ARRAYWIDTH = 8;
  localparam int unsigned DATASIZE   = 8;

  // Activation-to-first-result latency of the systolic array.
  function automatic int unsigned default_pipe_lat(input int unsigned array_w);
    return 2 * array_w;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WLOAD  = 3'd1,
    ST_WWRITE = 3'd2,
    ST_ALOAD  = 3'd3,
    ST_STREAM = 3'd4,
    ST_DRAIN  = 3'd5,
    ST_DONE   = 3'd6
  } seq_state_e;

  typedef struct packed {
    logic relu;
    logic acc;
    logic first;
  } tile_flags_t;

endpackage

// File: rtl/accel_sequencer_if.sv
// Control bundle between the tile issuer and the accelerator sequencer.
interface accel_sequencer_if #(
  parameter int unsigned ROWS_W = 8
);
  logic              start;
  logic              abort;
  logic [ROWS_W-1:0] cfg_rows;
  logic              cfg_relu;
  logic              cfg_acc;
  logic              cfg_first;

  logic busy;
  logic done;
  logic weight_buffer_load_en;
  logic weight_buffer_out_en;
  logic write_weight_en;
  logic input_buffer_load_en;
  logic input_buffer_delay_clear;
  logic input_buffer_out_en;
  logic output_buffer_load_clear;
  logic output_buffer_acc_clear;
  logic output_buffer_load_en;
  logic output_buffer_acc_enable;
  logic output_buffer_out_en;
  logic relu_en;

  modport master (
    output start, abort, cfg_rows, cfg_relu, cfg_acc, cfg_first,
    input  busy, done,
    input  weight_buffer_load_en, weight_buffer_out_en, write_weight_en,
    input  input_buffer_load_en, input_buffer_delay_clear, input_buffer_out_en,
    input  output_buffer_load_clear, output_buffer_acc_clear, output_buffer_load_en,
    input  output_buffer_acc_enable, output_buffer_out_en, relu_en
  );

  modport slave (
    input  start, abort, cfg_rows, cfg_relu, cfg_acc, cfg_first,
    output busy, done,
    output weight_buffer_load_en, weight_buffer_out_en, write_weight_en,
    output input_buffer_load_en, input_buffer_delay_clear, input_buffer_out_en,
    output output_buffer_load_clear, output_buffer_acc_clear, output_buffer_load_en,
    output output_buffer_acc_enable, output_buffer_out_en, relu_en
  );

endinterface

// File: rtl/accel_phase_counter.sv
// Down-counter timing each sequencer phase: load, decrement, zero flag.
module accel_phase_counter #(
  parameter int unsigned CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             zero_c
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/accel_sequencer.sv
// Tile sequencer: walks weight load/write, activation load, stream and drain
// phases, driving the buffer/array/ReLU enables from registered outputs.
module accel_sequencer
  import accel_sequencer_pkg::*;
#(
  parameter int unsigned ARRAY_W  = ARRAYWIDTH,
  parameter int unsigned ROWS_W   = 8,
  parameter int unsigned PIPE_LAT = default_pipe_lat(ARRAY_W)
) (
  input logic         clk,
  input logic         rst,
  accel_sequencer_if.slave bus
);

  // Longest phase is STREAM: cfg_rows + PIPE_LAT cycles at the largest row count.
  localparam int unsigned CNT_W = $clog2((2 ** ROWS_W) + PIPE_LAT);

  seq_state_e        state;
  logic [ROWS_W-1:0] rows_q;
  tile_flags_t       flags_q;

  logic             cnt_load_c;
  logic             cnt_dec_c;
  logic [CNT_W-1:0] cnt_val_c;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero_c;

  accel_phase_counter #(
    .CNT_W (CNT_W)
  ) u_phase_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load_c),
    .dec      (cnt_dec_c),
    .load_val (cnt_val_c),
    .count    (cnt),
    .zero_c   (cnt_zero_c)
  );

  // Counter holds remaining cycles minus one; reloaded at each phase boundary.
  always_comb begin
    cnt_load_c = 1'b0;
    cnt_dec_c  = 1'b0;
    cnt_val_c  = '0;
    unique case (state)
      ST_IDLE: begin
        if (bus.start && (bus.cfg_rows != '0)) begin
          cnt_load_c = 1'b1;
          cnt_val_c  = CNT_W'(ARRAY_W - 1);
        end
      end
      ST_WLOAD: begin
        cnt_load_c = cnt_zero_c;
        cnt_dec_c  = !cnt_zero_c;
        cnt_val_c  = CNT_W'(ARRAY_W - 1);
      end
      ST_WWRITE, ST_STREAM: begin
        cnt_load_c = cnt_zero_c;
        cnt_dec_c  = !cnt_zero_c;
        cnt_val_c  = CNT_W'(rows_q) - CNT_W'(1);
      end
      ST_ALOAD: begin
        cnt_load_c = cnt_zero_c;
        cnt_dec_c  = !cnt_zero_c;
        cnt_val_c  = CNT_W'(rows_q) + CNT_W'(PIPE_LAT) - CNT_W'(1);
      end
      ST_DRAIN: cnt_dec_c = 1'b1;
      default: ;
    endcase
    if (bus.abort && (state != ST_IDLE)) begin
      cnt_load_c = 1'b1;
      cnt_dec_c  = 1'b0;
      cnt_val_c  = '0;
    end
  end

  // State, latched config and registered enables; every enable is a pulse
  // re-asserted each cycle from the state being entered or held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                        <= ST_IDLE;
      rows_q                       <= '0;
      flags_q                      <= '0;
      bus.busy                     <= 1'b0;
      bus.done                     <= 1'b0;
      bus.weight_buffer_load_en    <= 1'b0;
      bus.weight_buffer_out_en     <= 1'b0;
      bus.write_weight_en          <= 1'b0;
      bus.input_buffer_load_en     <= 1'b0;
      bus.input_buffer_delay_clear <= 1'b0;
      bus.input_buffer_out_en      <= 1'b0;
      bus.output_buffer_load_clear <= 1'b0;
      bus.output_buffer_acc_clear  <= 1'b0;
      bus.output_buffer_load_en    <= 1'b0;
      bus.output_buffer_acc_enable <= 1'b0;
      bus.output_buffer_out_en     <= 1'b0;
      bus.relu_en                  <= 1'b0;
    end else begin
      bus.done                     <= 1'b0;
      bus.weight_buffer_load_en    <= 1'b0;
      bus.weight_buffer_out_en     <= 1'b0;
      bus.write_weight_en          <= 1'b0;
      bus.input_buffer_load_en     <= 1'b0;
      bus.input_buffer_delay_clear <= 1'b0;
      bus.input_buffer_out_en      <= 1'b0;
      bus.output_buffer_load_clear <= 1'b0;
      bus.output_buffer_acc_clear  <= 1'b0;
      bus.output_buffer_load_en    <= 1'b0;
      bus.output_buffer_acc_enable <= 1'b0;
      bus.output_buffer_out_en     <= 1'b0;
      bus.relu_en                  <= 1'b0;

      if (bus.abort && (state != ST_IDLE)) begin
        state    <= ST_IDLE;
        bus.busy <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (bus.start) begin
              if (bus.cfg_rows != '0) begin
                state                     <= ST_WLOAD;
                rows_q                    <= bus.cfg_rows;
                flags_q                   <= '{relu: bus.cfg_relu, acc: bus.cfg_acc,
                                               first: bus.cfg_first};
                bus.busy                  <= 1'b1;
                bus.weight_buffer_load_en <= 1'b1;
              end else begin
                bus.done <= 1'b1;
              end
            end
          end
          ST_WLOAD: begin
            if (cnt_zero_c) begin
              state                    <= ST_WWRITE;
              bus.weight_buffer_out_en <= 1'b1;
              bus.write_weight_en      <= 1'b1;
            end else begin
              bus.weight_buffer_load_en <= 1'b1;
            end
          end
          ST_WWRITE: begin
            if (cnt_zero_c) begin
              state                        <= ST_ALOAD;
              bus.input_buffer_load_en     <= 1'b1;
              bus.input_buffer_delay_clear <= 1'b1;
              bus.output_buffer_load_clear <= 1'b1;
              bus.output_buffer_acc_clear  <= flags_q.first;
            end else begin
              bus.weight_buffer_out_en <= 1'b1;
              bus.write_weight_en      <= 1'b1;
            end
          end
          ST_ALOAD: begin
            if (cnt_zero_c) begin
              state                        <= ST_STREAM;
              bus.input_buffer_out_en      <= 1'b1;
              bus.output_buffer_load_en    <= (PIPE_LAT == 0);
              bus.output_buffer_acc_enable <= flags_q.acc && (PIPE_LAT == 0);
            end else begin
              bus.input_buffer_load_en <= 1'b1;
            end
          end
          ST_STREAM: begin
            if (cnt_zero_c) begin
              state                    <= ST_DRAIN;
              bus.output_buffer_out_en <= 1'b1;
              bus.relu_en              <= flags_q.relu;
            end else begin
              // Results arrive once the remaining count drops below the row count.
              bus.input_buffer_out_en      <= 1'b1;
              bus.output_buffer_load_en    <= (cnt <= CNT_W'(rows_q));
              bus.output_buffer_acc_enable <= flags_q.acc && (cnt <= CNT_W'(rows_q));
            end
          end
          ST_DRAIN: begin
            if (cnt_zero_c) begin
              state    <= ST_DONE;
              bus.done <= 1'b1;
            end else begin
              bus.output_buffer_out_en <= 1'b1;
              bus.relu_en              <= flags_q.relu;
            end
          end
          ST_DONE: begin
            state    <= ST_IDLE;
            bus.busy <= 1'b0;
          end
          default: begin
            state    <= ST_IDLE;
            bus.busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
